// File: rtl/red_pitaya_sys_initiator.sv
// rtl/red_pitaya_sys_initiator.sv - sys_* register bus initiator with ack timeout
//
// Purpose: takes one command at a time on a valid/ready port, issues a single-cycle
// sys_wen/sys_ren strobe, waits for sys_ack_i (bounded by TMO_CYC cycles) and returns
// read data plus error/timeout status on a valid/ready response port.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake
//   cmd_we_i/addr/wdata/sel          command payload (1=write, 0=read)
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_rdata_o/rsp_err_o/rsp_tmo_o  response payload
//   sys_addr/wdata/sel_o             bus address, write data, byte select
//   sys_wen_o/sys_ren_o              one-cycle write/read strobes
//   sys_rdata_i/sys_err_i/sys_ack_i  bus responder return path
//   tmo_cnt_o                        saturating count of timeout events

module red_pitaya_sys_initiator #(
    parameter int unsigned TMO_CYC = 255,
    parameter int unsigned TCW     = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic           cmd_we_i,
    input  logic [31:0]    cmd_addr_i,
    input  logic [31:0]    cmd_wdata_i,
    input  logic [3:0]     cmd_sel_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [31:0]    rsp_rdata_o,
    output logic           rsp_err_o,
    output logic           rsp_tmo_o,
    output logic [31:0]    sys_addr_o,
    output logic [31:0]    sys_wdata_o,
    output logic [3:0]     sys_sel_o,
    output logic           sys_wen_o,
    output logic           sys_ren_o,
    input  logic [31:0]    sys_rdata_i,
    input  logic           sys_err_i,
    input  logic           sys_ack_i,
    output logic [TCW-1:0] tmo_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        we_q;
    logic [15:0] wait_cnt;
    logic        cmd_fire;
    logic        rsp_fire;
    logic        expire;

    assign cmd_fire = cmd_valid_i && (state == IDLE);
    assign rsp_fire = rsp_ready_i && (state == RESP);

    // wait_cnt is 0 in the first WAIT cycle, so the last allowed ack cycle is TMO_CYC-1.
    assign expire = (wait_cnt == 16'(TMO_CYC - 1));

    // Handshake outputs decode straight from the state register.
    assign cmd_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = STROBE;
            STROBE:  state_nxt = WAIT;
            WAIT:    if (sys_ack_i || expire) state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            wait_cnt    <= 16'd0;
            sys_addr_o  <= 32'd0;
            sys_wdata_o <= 32'd0;
            sys_sel_o   <= 4'd0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            tmo_cnt_o   <= '0;
        end else begin
            sys_wen_o <= 1'b0;
            sys_ren_o <= 1'b0;

            if (cmd_fire) begin
                sys_addr_o  <= cmd_addr_i;
                sys_wdata_o <= cmd_wdata_i;
                sys_sel_o   <= cmd_sel_i;
                we_q        <= cmd_we_i;
                sys_wen_o   <= cmd_we_i;
                sys_ren_o   <= ~cmd_we_i;
            end

            // An ack seen during the strobe cycle belongs to an earlier access; ignore it.
            if (state == STROBE) begin
                wait_cnt <= 16'd0;
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
                if (sys_ack_i) begin
                    rsp_rdata_o <= (we_q || sys_err_i) ? 32'd0 : sys_rdata_i;
                    rsp_err_o   <= sys_err_i;
                    rsp_tmo_o   <= 1'b0;
                end else if (expire) begin
                    rsp_rdata_o <= 32'd0;
                    rsp_err_o   <= 1'b1;
                    rsp_tmo_o   <= 1'b1;
                    if (tmo_cnt_o != {TCW{1'b1}}) begin
                        tmo_cnt_o <= tmo_cnt_o + TCW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_sys_initiator.sv
// tb/tb_red_pitaya_sys_initiator.sv - scoreboard bench for red_pitaya_sys_initiator
module tb_red_pitaya_sys_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_rdata;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren, sys_err, sys_ack;
    logic [15:0] tmo_cnt;

    logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_err2, rsp_tmo2;
    logic        sys_wen2, sys_ren2;
    logic [31:0] rsp_rdata2, sys_addr2, sys_wdata2;
    logic [3:0]  sys_sel2;
    logic [1:0]  tmo_cnt2;

    always #5 clk = ~clk;

    red_pitaya_sys_initiator #(.TMO_CYC(8), .TCW(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
        .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel),
        .sys_wen_o(sys_wen), .sys_ren_o(sys_ren), .sys_rdata_i(sys_rdata),
        .sys_err_i(sys_err), .sys_ack_i(sys_ack), .tmo_cnt_o(tmo_cnt)
    );

    // Narrow-counter instance: exercises timeout saturation within a short run.
    red_pitaya_sys_initiator #(.TMO_CYC(1), .TCW(2)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_we_i(1'b0),
        .cmd_addr_i(32'h0000_0100), .cmd_wdata_i(32'd0), .cmd_sel_i(4'hF),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(1'b1), .rsp_rdata_o(rsp_rdata2),
        .rsp_err_o(rsp_err2), .rsp_tmo_o(rsp_tmo2),
        .sys_addr_o(sys_addr2), .sys_wdata_o(sys_wdata2), .sys_sel_o(sys_sel2),
        .sys_wen_o(sys_wen2), .sys_ren_o(sys_ren2), .sys_rdata_i(32'd0),
        .sys_err_i(1'b0), .sys_ack_i(1'b0), .tmo_cnt_o(tmo_cnt2)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder model
    int          cfg_dly = 0;
    logic [31:0] cfg_rd  = 32'd0;
    logic        cfg_err = 1'b0;
    logic        cfg_stale = 1'b0;
    int          cd = 0;
    logic [31:0] p_rd;
    logic        p_err;

    initial begin
        sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = 32'd0;
        p_rd = 32'd0; p_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = 32'd0;
            if (cd == 1) begin
                sys_ack = 1'b1; sys_err = p_err; sys_rdata = p_rd;
            end
            if (cd > 0) cd--;
            if (sys_wen || sys_ren) begin
                cd = cfg_dly; p_rd = cfg_rd; p_err = cfg_err;
                if (cfg_stale) begin
                    sys_ack = 1'b1; sys_rdata = 32'hBAD0_0000;
                end
            end
        end
    end

    // Monitor / scoreboard
    int          acc_cyc = 0, rise_cyc = 0, wen_cnt = 0, ren_cnt = 0, rsp2_n = 0;
    logic        was_valid = 1'b0;
    logic [33:0] rise_pl = '0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_sel = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sys_wen) wen_cnt++;
                if (sys_ren) ren_cnt++;
                if (sys_wen || sys_ren) begin
                    cap_addr = sys_addr; cap_wdata = sys_wdata; cap_sel = sys_sel;
                end
                if (rsp_valid2) rsp2_n++;
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
                if (rsp_valid && !was_valid) begin
                    rise_cyc = cyc;
                    rise_pl  = {rsp_err, rsp_tmo, rsp_rdata};
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_rsp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
                        check_eq("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
                        check_eq("rsp_stable", 64'(rise_pl), 64'({rsp_err, rsp_tmo, rsp_rdata}));
                        if (e.lat > 0) check_eq("latency", 64'(rise_cyc - acc_cyc), 64'(e.lat));
                    end
                end
            end
            was_valid = rsp_valid && !rst;
        end
    end

    task automatic wait_accept();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(cmd_valid && cmd_ready) && k < 200);
        if (!(cmd_valid && cmd_ready)) check_eq("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) check_eq("idle_timeout", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic err, input logic tmo, input int lat);
        exp_t e;
        e.rdata = rd; e.err = err; e.tmo = tmo; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int dly, input logic [31:0] rd,
                        input logic err, input logic stale, input logic [31:0] erd,
                        input logic eerr, input logic etmo, input int lat);
        push_exp(erd, eerr, etmo, lat);
        @(posedge clk); #1;
        cfg_dly = dly; cfg_rd = rd; cfg_err = err; cfg_stale = stale;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
        rsp_ready = 1'b1; cmd_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_rsp_err", 64'({rsp_err, rsp_tmo}), 64'd0);
        check_eq("rst_sys_addr", 64'(sys_addr), 64'd0);
        check_eq("rst_sys_wdata_sel", 64'({sys_wdata, sys_sel}), 64'd0);
        check_eq("rst_strobes", 64'({sys_wen, sys_ren}), 64'd0);
        check_eq("rst_tmo_cnt", 64'(tmo_cnt), 64'd0);

        // Read with ack in N+2
        wen_cnt = 0; ren_cnt = 0;
        send(1'b0, 32'h4, 32'd0, 4'hF, 1, 32'h89AB_CDE0, 1'b0, 1'b0, 32'h89AB_CDE0, 1'b0, 1'b0, 3);
        wait_idle();
        check_eq("rd_ren_pulses", 64'(ren_cnt), 64'd1);
        check_eq("rd_wen_pulses", 64'(wen_cnt), 64'd0);
        check_eq("rd_addr", 64'(cap_addr), 64'h4);

        // Write
        wen_cnt = 0; ren_cnt = 0;
        send(1'b1, 32'h30, 32'hFE, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3);
        wait_idle();
        check_eq("wr_wen_pulses", 64'(wen_cnt), 64'd1);
        check_eq("wr_ren_pulses", 64'(ren_cnt), 64'd0);
        check_eq("wr_addr", 64'(cap_addr), 64'h30);
        check_eq("wr_wdata", 64'(cap_wdata), 64'hFE);
        check_eq("wr_sel", 64'(cap_sel), 64'hF);
        check_eq("wr_addr_held", 64'(sys_addr), 64'h30);

        // Timeout, then a late ack at N+12
        send(1'b0, 32'h40, 32'd0, 4'hF, 11, 32'h1234, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 10);
        wait_idle();
        check_eq("tmo_cnt_1", 64'(tmo_cnt), 64'd1);

        // Ack carrying an error
        send(1'b0, 32'h44, 32'd0, 4'hF, 2, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4);
        wait_idle();
        check_eq("err_tmo_cnt", 64'(tmo_cnt), 64'd1);

        // Ack coinciding with the final wait cycle
        send(1'b0, 32'h48, 32'd0, 4'hF, 8, 32'h55AA_55AA, 1'b0, 1'b0, 32'h55AA_55AA, 1'b0, 1'b0, 10);
        wait_idle();
        check_eq("edge_tmo_cnt", 64'(tmo_cnt), 64'd1);

        // Ack only during the strobe cycle is stale
        send(1'b0, 32'h4C, 32'd0, 4'hF, 0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 10);
        wait_idle();
        check_eq("stale_tmo_cnt", 64'(tmo_cnt), 64'd2);

        // Response backpressure with the next command already offered
        rsp_ready = 1'b0;
        send(1'b0, 32'h50, 32'd0, 4'hF, 1, 32'hA5A5_0001, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 3);
        push_exp(32'hB0B0_0002, 1'b0, 1'b0, 3);
        @(posedge clk); #1;
        cfg_dly = 1; cfg_rd = 32'hB0B0_0002; cfg_err = 1'b0; cfg_stale = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h54;
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("bp_rdata_held", 64'(rsp_rdata), 64'hA5A5_0001);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_accept();
        wait_idle();

        // Three back-to-back reads
        ren_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h60 + 32'(4 * i), 32'd0, 4'hF, 1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0,
                 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, 3);
        end
        wait_idle();
        check_eq("b2b_ren_pulses", 64'(ren_cnt), 64'd3);

        // Reset while waiting for an ack
        send(1'b0, 32'h70, 32'd0, 4'hF, 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check_eq("mid_rst_strobes", 64'({sys_wen, sys_ren}), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_tmo_cnt", 64'(tmo_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Saturating timeout counter on the narrow instance
        rsp2_n = 0;
        @(posedge clk); #1;
        cmd_valid2 = 1'b1;
        for (int k = 0; k < 200 && rsp2_n < 3; k++) @(negedge clk);
        check_eq("sat_reached_3", 64'(rsp2_n >= 3), 64'd1);
        check_eq("sat_cnt_3", 64'(tmo_cnt2), 64'd3);
        for (int k = 0; k < 200 && rsp2_n < 5; k++) @(negedge clk);
        check_eq("sat_cnt_held", 64'(tmo_cnt2), 64'd3);
        check_eq("sat_rsp_tmo", 64'({rsp_err2, rsp_tmo2}), 64'h3);
        cmd_valid2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
